// File: rtl/spram_fifo_pkg.sv
// Shared constants and FSM state type for the single-port-RAM FIFO controller.
package spram_fifo_pkg;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int LW    = 7;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/spram_fifo_if.sv
// Push/pop stream and status signals of the FIFO; slave is the FIFO side, master the user side.
interface spram_fifo_if;
    import spram_fifo_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, full, empty
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, full, empty
    );
endinterface

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller over an external 64x8 single-port RAM with a registered head entry.
// Optional macro SPRAM_FIFO_BYPASS_EN loads pushes straight into the head register when the FIFO drains.
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    spram_fifo_if.slave    fifo,
    output logic [DW-1:0]  ram_data,
    output logic [AW-1:0]  ram_addr,
    output logic           ram_we,
    input  logic [DW-1:0]  ram_q
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] ram_cnt_q, ram_cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic rd_req_s;
    logic full_s;
    logic in_ready_s;
    logic push_s;
    logic pop_s;
    logic bypass_s;
    logic wr_s;

    // Handshake qualifiers; a pending RAM read takes the single port, so it blocks pushes.
    always_comb begin
        full_s     = (level_q == LVL_FULL);
        rd_req_s   = (state_q == IDLE) && !out_valid_q && (ram_cnt_q != 7'd0);
        in_ready_s = rst_n && !full_s && !rd_req_s;
        push_s     = fifo.in_valid && in_ready_s;
        pop_s      = out_valid_q && fifo.out_ready;
`ifdef SPRAM_FIFO_BYPASS_EN
        bypass_s   = push_s && ((level_q == 7'd0) || ((level_q == 7'd1) && pop_s));
`else
        bypass_s   = 1'b0;
`endif
        wr_s       = push_s && !bypass_s;
    end

    // RAM port: a write when a push goes to RAM, otherwise a read of the head slot.
    always_comb begin
        ram_we   = wr_s;
        ram_addr = wr_s ? wr_ptr_q : rd_ptr_q;
        ram_data = wr_s ? fifo.in_data : 8'h00;
    end

    // Next-state: pointers, counters, read FSM and head register.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + {5'd0, wr_s};
        rd_ptr_d  = rd_ptr_q + {5'd0, rd_req_s};
        ram_cnt_d = ram_cnt_q + {6'd0, wr_s} - {6'd0, rd_req_s};
        level_d   = level_q + {6'd0, push_s} - {6'd0, pop_s};
        state_d   = state_q;

        case (state_q)
            IDLE: begin
                if (rd_req_s) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // RD_WAIT and bypass never coincide: RD_WAIT implies level>=1 with no head to pop.
        if (state_q == RD_WAIT) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_q;
        end else if (bypass_s) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo.in_data;
        end else if (pop_s) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // State registers with synchronous active-low reset; an in-flight read is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 6'd0;
            rd_ptr_q    <= 6'd0;
            ram_cnt_q   <= 7'd0;
            level_q     <= 7'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign fifo.in_ready  = in_ready_s;
    assign fifo.out_valid = out_valid_q;
    assign fifo.out_data  = out_data_q;
    assign fifo.level     = level_q;
    assign fifo.full      = rst_n && full_s;
    assign fifo.empty     = !rst_n || (level_q == 7'd0);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed self-checking bench for spram_fifo_ctrl with a behavioural 64x8 single-port RAM.
module tb_spram_fifo_ctrl;
    import spram_fifo_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    spram_fifo_if fifo_if ();

    spram_fifo_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fifo     (fifo_if),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        else        ram_q <= mem[ram_addr];
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fifo_if.in_valid  = 1'b0;
        fifo_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts and ends on a negedge; holds in_valid until accepted or the budget runs out.
    task automatic push_item(input logic [7:0] d, output logic we, output logic [5:0] addr,
                             output logic ok);
        ok = 1'b0; we = 1'b0; addr = 6'd0;
        fifo_if.in_valid = 1'b1;
        fifo_if.in_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (fifo_if.in_ready) begin
                ok = 1'b1; we = ram_we; addr = ram_addr;
            end
            @(negedge clk);
        end
        fifo_if.in_valid = 1'b0;
    endtask

    task automatic pop_item(output logic [7:0] d, output logic ok);
        ok = 1'b0; d = 8'h00;
        fifo_if.out_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (fifo_if.out_valid) begin
                ok = 1'b1; d = fifo_if.out_data;
            end
            @(negedge clk);
        end
        fifo_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fifo_if.in_valid  = 1'b1;
        fifo_if.in_data   = 8'h11;
        fifo_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (fifo_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", fifo_if.out_valid); end
        n_checks++; if (fifo_if.level !== 7'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_if.level); end
        n_checks++; if (fifo_if.empty !== 1'b1 || fifo_if.full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", fifo_if.empty, fifo_if.full); end
        n_checks++; if (ram_we !== 1'b0 || fifo_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_we_ready got we=%b rdy=%b exp 0/0", ram_we, fifo_if.in_ready); end
        fifo_if.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++; if (fifo_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", fifo_if.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_push3();
        logic [7:0] data [3];
        logic [6:0] exp_wa [3];
        logic we, ok;
        logic [5:0] addr;
        data = '{8'hA5, 8'h5A, 8'h3C};
`ifdef SPRAM_FIFO_BYPASS_EN
        exp_wa = '{7'h00, 7'h40, 7'h41};
`else
        exp_wa = '{7'h40, 7'h41, 7'h42};
`endif
        for (int i = 0; i < 3; i++) begin
            push_item(data[i], we, addr, ok);
            n_checks++;
            if (!ok || {we, addr} !== exp_wa[i]) begin
                n_fail++; $display("FAIL push3_write%0d got ok=%b we=%b addr=%0d exp we/addr=%h", i, ok, we, addr, exp_wa[i]);
            end
        end
        n_checks++; if (fifo_if.out_valid !== 1'b1 || fifo_if.out_data !== 8'hA5) begin n_fail++; $display("FAIL push3_head got v=%b d=%h exp 1/a5", fifo_if.out_valid, fifo_if.out_data); end
        n_checks++; if (fifo_if.level !== 7'd3) begin n_fail++; $display("FAIL push3_level got %0d exp 3", fifo_if.level); end
    endtask

    task automatic test_full();
        logic we, ok;
        logic [5:0] addr;
        logic [7:0] d;
        int acc = 0;
        int bad_we = 0;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            push_item(8'(i), we, addr, ok);
            if (ok) acc++;
        end
        n_checks++; if (acc != 64) begin n_fail++; $display("FAIL full_accepted got %0d exp 64", acc); end
        #1;
        n_checks++; if (fifo_if.level !== 7'd64 || fifo_if.full !== 1'b1) begin n_fail++; $display("FAIL full_flag got level=%0d full=%b exp 64/1", fifo_if.level, fifo_if.full); end
        n_checks++; if (fifo_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", fifo_if.in_ready); end
        fifo_if.in_valid = 1'b1;
        fifo_if.in_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ram_we !== 1'b0 || fifo_if.in_ready !== 1'b0) bad_we++;
            @(negedge clk);
        end
        fifo_if.in_valid = 1'b0;
        n_checks++; if (bad_we != 0 || fifo_if.level !== 7'd64) begin n_fail++; $display("FAIL full_push_held got bad=%0d level=%0d exp 0/64", bad_we, fifo_if.level); end
        for (int i = 0; i < 64; i++) begin
            pop_item(d, ok);
            n_checks++;
            if (!ok || d !== 8'(i)) begin n_fail++; $display("FAIL drain_%0d got ok=%b d=%h exp %h", i, ok, d, 8'(i)); end
        end
        n_checks++; if (fifo_if.level !== 7'd0 || fifo_if.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got level=%0d empty=%b exp 0/1", fifo_if.level, fifo_if.empty); end
    endtask

    task automatic test_stream();
        logic [7:0] q [$];
        logic [7:0] exp_d;
        int sent = 0;
        int recv = 0;
        int lvl_err = 0;
        int cyc = 0;
        do_reset();
        while (recv < 100 && cyc < 3000) begin
            fifo_if.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            fifo_if.in_data   = 8'(sent * 7 + 3);
            fifo_if.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (fifo_if.level !== 7'(q.size())) lvl_err++;
            if (fifo_if.out_valid && fifo_if.out_ready) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 8'hXX;
                n_checks++;
                if (fifo_if.out_data !== exp_d) begin n_fail++; $display("FAIL stream_item%0d got %h exp %h", recv, fifo_if.out_data, exp_d); end
                recv++;
            end
            if (fifo_if.in_valid && fifo_if.in_ready) begin
                q.push_back(fifo_if.in_data);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        fifo_if.in_valid  = 1'b0;
        fifo_if.out_ready = 1'b0;
        #1;
        n_checks++; if (recv != 100) begin n_fail++; $display("FAIL stream_count got %0d exp 100", recv); end
        n_checks++; if (lvl_err != 0) begin n_fail++; $display("FAIL stream_level_track got %0d errors exp 0", lvl_err); end
        n_checks++; if (fifo_if.level !== 7'd0 || fifo_if.empty !== 1'b1) begin n_fail++; $display("FAIL stream_end got level=%0d empty=%b exp 0/1", fifo_if.level, fifo_if.empty); end
        @(negedge clk);
    endtask

    task automatic test_reset_rdwait();
        logic we, ok;
        logic [5:0] addr;
        logic [7:0] d;
        do_reset();
        push_item(8'h10, we, addr, ok);
        push_item(8'h20, we, addr, ok);
        push_item(8'h30, we, addr, ok);
        pop_item(d, ok);
        n_checks++; if (!ok || d !== 8'h10) begin n_fail++; $display("FAIL rdw_first_pop got ok=%b d=%h exp 10", ok, d); end
        @(negedge clk);
        n_checks++; if (fifo_if.level !== 7'd2 || fifo_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_pre got level=%0d v=%b exp 2/0", fifo_if.level, fifo_if.out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (fifo_if.out_valid !== 1'b0 || fifo_if.level !== 7'd0) begin n_fail++; $display("FAIL rdw_reset got v=%b level=%0d exp 0/0", fifo_if.out_valid, fifo_if.level); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (fifo_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_discard got v=%b exp 0", fifo_if.out_valid); end
        push_item(8'h42, we, addr, ok);
        n_checks++; if (!ok || fifo_if.level !== 7'd1) begin n_fail++; $display("FAIL rdw_push got ok=%b level=%0d exp 1/1", ok, fifo_if.level); end
        pop_item(d, ok);
        n_checks++; if (!ok || d !== 8'h42 || fifo_if.level !== 7'd0) begin n_fail++; $display("FAIL rdw_pop got ok=%b d=%h level=%0d exp 1/42/0", ok, d, fifo_if.level); end
    endtask

    task automatic test_latency();
        logic [7:0] d;
        logic ok;
        logic exp_v;
        do_reset();
        fifo_if.in_valid = 1'b1;
        fifo_if.in_data  = 8'h77;
        #1;
        n_checks++; if (fifo_if.in_ready !== 1'b1 || fifo_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycleN got rdy=%b v=%b exp 1/0", fifo_if.in_ready, fifo_if.out_valid); end
        @(negedge clk);
        fifo_if.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
`ifdef SPRAM_FIFO_BYPASS_EN
            exp_v = 1'b1;
`else
            exp_v = (k == 3);
`endif
            n_checks++; if (fifo_if.out_valid !== exp_v) begin n_fail++; $display("FAIL lat_N+%0d got v=%b exp %b", k, fifo_if.out_valid, exp_v); end
            if (k < 3) @(negedge clk);
        end
        n_checks++; if (fifo_if.out_data !== 8'h77) begin n_fail++; $display("FAIL lat_data got %h exp 77", fifo_if.out_data); end
        pop_item(d, ok);
    endtask

    initial begin
        fifo_if.in_valid  = 1'b0;
        fifo_if.in_data   = 8'h00;
        fifo_if.out_ready = 1'b0;
        test_reset();
        test_push3();
        test_full();
        test_stream();
        test_reset_rdwait();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
